reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
// Reset controller for the reset-circuit library. Merges NUM_SRC raw reset
// requests (watchdog, soft reset, debug, pin), debounces each so glitches
// shorter than FILT_CYC cycles are rejected, and asserts all downstream domain
// resets together. Releases domains in order 0..NUM_DOM-1, REL_DLY cycles apart.
// Records which sources caused the last reset.
// PARAMETERS
// NUM_SRC   4   number of reset request sources
// NUM_DOM   3   number of sequenced reset domains
// FILT_CYC  4   consecutive synced-high cycles before a request is accepted (>=1)
// HOLD_CYC  16  minimum cycles all domains are held in reset (>=1)
// REL_DLY   8   cycles between release steps (>=1)
// PORTS
// clk        in   1        system clock
// rst_n      in   1        async active-low reset (power-on)
// rst_req    in   NUM_SRC  raw active-high requests, asynchronous to clk
// src_en     in   NUM_SRC  per-source enable; a masked source is ignored after the synchronizer
// cause_clr  in   1        1-cycle pulse, clears cause
// dom_rst_n  out  NUM_DOM  registered active-low domain resets
// seq_busy   out  1        high in any state other than IDLE
// cause      out  NUM_SRC  sticky OR of accepted sources since last clear
// BEHAVIOUR
// - rst_n low (async): dom_rst_n=0, seq_busy=1, cause=0, synchronizers and filters cleared,
//   FSM=ASSERT with hold count 0. On rst_n release, a full hold + release sequence runs.
// - Sync: each rst_req bit passes through a 2-FF synchronizer; src_en masks the sync output.
// - Filter per source: counter increments on each edge with masked sync high, saturating at FILT_CYC.
//   It clears on any low. filt[i]=1 while the count equals FILT_CYC; it drops on the edge the sync output goes low.
// - Latency: rst_req stable high from sampling edge 1 -> filt high after edge FILT_CYC+2.
//   dom_rst_n all 0 after edge FILT_CYC+3 (FILT_CYC=4: edge 7).
// - FSM states IDLE, ASSERT, WAIT_CLR, RELEASE:
//   IDLE: dom_rst_n all 1, seq_busy=0. Any filt bit -> ASSERT.
//   ASSERT: dom_rst_n all 0. Counts HOLD_CYC cycles, then -> WAIT_CLR.
//   WAIT_CLR: dom_rst_n all 0. When filt==0 -> RELEASE with step=0 and delay count 0.
//   RELEASE: each REL_DLY cycles, dom_rst_n[step] goes to 1 and step increments.
//     After domain NUM_DOM-1 is released -> IDLE on the same edge.
//     Domain k is high (k+1)*REL_DLY cycles after RELEASE entry.
//   Any filt bit in RELEASE -> ASSERT: all dom_rst_n=0 next edge, hold count restarts.
//   Any filt bit in ASSERT: ignored; the hold count does not restart.
// - Domains released so far never re-release out of order; release order is always 0 first.
// - cause: on every edge where FSM is not in reset and filt[i]=1, cause[i] is set.
//   cause_clr clears it, but set has priority over clear for the same bit in the same edge.
// - Widths: counters sized $clog2(max+1); no wrap, every counter saturates or resets.
// TESTING
// 1 Power-on: rst_n low 5 cycles then high, rst_req=0. All dom_rst_n=0 for 16 cycles.
//   Then dom_rst_n[0] up at +8, [1] at +16, [2] at +24. seq_busy falls with [2]. cause=0.
// 2 Glitch reject: rst_req[1] high 3 synced cycles. No dom_rst_n change, cause=0.
//   A 4-cycle pulse asserts all resets at edge 7 and sets cause=4'b0010.
// 3 Long request: rst_req[0] high 100 cycles. Resets are held for the request duration plus filter/sync delay.
//   Release starts only after filt drops, then follows the 8/16/24 spacing.
// 4 Re-trigger mid-release: assert rst_req[2] after dom_rst_n[0] is up. All domains return to 0 next edge.
//   A full 16-cycle hold follows, then the release restarts from domain 0. cause has both bits.
// 5 Masking/clear: src_en[3]=0, rst_req[3] high 50 cycles -> no reset.
//   A cause_clr pulse in the same cycle as a new filt bit leaves that bit set.
// 6 Async reset mid-RELEASE: rst_n low 1 cycle. All outputs go to reset values immediately,
//   then a full power-on sequence runs.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset controller: syncs and debounces reset requests, holds all
// domains in reset, then releases them in order with fixed spacing.
module reset_sequencer #(
   parameter int NUM_SRC  = 4,
   parameter int NUM_DOM  = 3,
   parameter int FILT_CYC = 4,
   parameter int HOLD_CYC = 16,
   parameter int REL_DLY  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] rst_req,
   input  logic [NUM_SRC-1:0] src_en,
   input  logic               cause_clr,
   output logic [NUM_DOM-1:0] dom_rst_n,
   output logic               seq_busy,
   output logic [NUM_SRC-1:0] cause
);

   localparam int FW = $clog2(FILT_CYC + 1);
   localparam int HW = $clog2(HOLD_CYC + 1);
   localparam int DW = $clog2(REL_DLY + 1);
   localparam int SW = $clog2(NUM_DOM + 1);

   typedef enum logic [1:0] {
      IDLE,
      ASSERT,
      WAIT_CLR,
      RELEASE
   } state_t;

   logic [NUM_SRC-1:0] sync1;
   logic [NUM_SRC-1:0] sync2;
   logic [NUM_SRC-1:0] masked;
   logic [NUM_SRC-1:0] filt;
   logic [FW-1:0]      fcnt [NUM_SRC];
   logic               any_filt;

   state_t             state;
   state_t             state_d;
   logic [HW-1:0]      hold;
   logic [HW-1:0]      hold_d;
   logic [DW-1:0]      dly;
   logic [DW-1:0]      dly_d;
   logic [SW-1:0]      step;
   logic [SW-1:0]      step_d;
   logic [NUM_DOM-1:0] dom_q;
   logic [NUM_DOM-1:0] dom_d;

   assign masked   = sync2 & src_en;
   assign any_filt = |filt;

   // two-flop synchronizer for the raw asynchronous requests
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= rst_req;
         sync2 <= sync1;
      end
   end

   // per-source debounce counter, saturating, cleared by any low sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SRC; i++) fcnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!masked[i])
               fcnt[i] <= '0;
            else if (fcnt[i] != FW'(FILT_CYC))
               fcnt[i] <= fcnt[i] + 1'b1;
         end
      end
   end

   // a source is accepted only while its counter sits at saturation
   always_comb begin
      filt = '0;
      for (int i = 0; i < NUM_SRC; i++)
         filt[i] = (fcnt[i] == FW'(FILT_CYC));
   end

   // sequencer state, counters and registered domain resets
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ASSERT;
         hold  <= '0;
         dly   <= '0;
         step  <= '0;
         dom_q <= '0;
      end else begin
         state <= state_d;
         hold  <= hold_d;
         dly   <= dly_d;
         step  <= step_d;
         dom_q <= dom_d;
      end
   end

   // next-state: hold, wait for requests to clear, stepped release
   always_comb begin
      state_d = state;
      hold_d  = hold;
      dly_d   = dly;
      step_d  = step;
      unique case (state)
         IDLE: begin
            if (any_filt) begin
               state_d = ASSERT;
               hold_d  = '0;
            end
         end
         ASSERT: begin
            if (hold == HW'(HOLD_CYC - 1)) begin
               state_d = WAIT_CLR;
               hold_d  = '0;
            end else begin
               hold_d = hold + 1'b1;
            end
         end
         WAIT_CLR: begin
            if (!any_filt) begin
               state_d = RELEASE;
               step_d  = '0;
               dly_d   = '0;
            end
         end
         RELEASE: begin
            if (any_filt) begin
               state_d = ASSERT;
               hold_d  = '0;
               dly_d   = '0;
               step_d  = '0;
            end else if (dly == DW'(REL_DLY - 1)) begin
               dly_d = '0;
               if (step == SW'(NUM_DOM - 1)) begin
                  state_d = IDLE;
                  step_d  = '0;
               end else begin
                  step_d = step + 1'b1;
               end
            end else begin
               dly_d = dly + 1'b1;
            end
         end
         default: state_d = ASSERT;
      endcase
   end

   // outputs for the coming state; released domains are those below step
   always_comb begin
      dom_d = '0;
      unique case (state_d)
         IDLE:    dom_d = '1;
         RELEASE: begin
            for (int k = 0; k < NUM_DOM; k++)
               dom_d[k] = (SW'(k) < step_d);
         end
         default: dom_d = '0;
      endcase
   end

   // sticky cause; a new accepted source wins over a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cause <= '0;
      else
         cause <= (cause & ~{NUM_SRC{cause_clr}}) | filt;
   end

   assign dom_rst_n = dom_q;
   assign seq_busy  = (state != IDLE);

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random traffic,
// checked every cycle against a timestamp-based reference model.
module tb_reset_sequencer;

   localparam int FILT = 4;
   localparam int HOLD = 16;
   localparam int RDLY = 8;
   localparam int NDOM = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] rst_req;
   logic [3:0] src_en;
   logic       cause_clr;
   logic [2:0] dom_rst_n;
   logic       seq_busy;
   logic [3:0] cause;

   int n_vec = 0;
   int n_bad = 0;

   localparam int M_IDLE = 0;
   localparam int M_HOLD = 1;
   localparam int M_WAIT = 2;
   localparam int M_REL  = 3;

   int         cyc = 0;
   int         t_a = 0;
   int         t_r = 0;
   int         mode = M_HOLD;
   logic [3:0] req_h [0:5];
   logic [3:0] en_h  [0:3];
   logic [3:0] m_filt;
   logic [3:0] m_cause;

   always #5 clk = ~clk;

   reset_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rst_req   (rst_req),
      .src_en    (src_en),
      .cause_clr (cause_clr),
      .dom_rst_n (dom_rst_n),
      .seq_busy  (seq_busy),
      .cause     (cause)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 30)
            $display("FAIL %s: got %0h want %0h at cycle %0d",
                     tag, got, exp, cyc);
      end
   endtask

   function automatic logic [2:0] m_dom();
      logic [2:0] d;
      for (int k = 0; k < NDOM; k++) begin
         if (mode == M_REL)
            d[k] = ((cyc - t_r) >= (k + 1) * RDLY);
         else
            d[k] = (mode == M_IDLE);
      end
      return d;
   endfunction

   task automatic m_reset();
      mode    = M_HOLD;
      t_a     = cyc;
      m_filt  = '0;
      m_cause = '0;
      for (int j = 0; j < 6; j++) req_h[j] = '0;
      for (int j = 0; j < 4; j++) en_h[j] = '0;
   endtask

   task automatic step();
      logic [3:0] rq;
      logic [3:0] en;
      logic       clr;
      rq  = rst_req;
      en  = src_en;
      clr = cause_clr;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         m_reset();
      end else begin
         case (mode)
            M_IDLE: if (|m_filt) begin mode = M_HOLD; t_a = cyc; end
            M_HOLD: if (cyc - t_a == HOLD) mode = M_WAIT;
            M_WAIT: if (m_filt == 0) begin mode = M_REL; t_r = cyc; end
            default: begin
               if (|m_filt) begin
                  mode = M_HOLD;
                  t_a  = cyc;
               end else if (cyc - t_r == NDOM * RDLY) begin
                  mode = M_IDLE;
               end
            end
         endcase
         m_cause = (m_cause & ~{4{clr}}) | m_filt;
         for (int j = 5; j > 0; j--) req_h[j] = req_h[j-1];
         for (int j = 3; j > 0; j--) en_h[j] = en_h[j-1];
         req_h[0] = rq;
         en_h[0]  = en;
         m_filt = '1;
         for (int j = 0; j < FILT; j++)
            m_filt = m_filt & req_h[j+2] & en_h[j];
      end
      #1;
      chk("dom_rst_n", 32'(dom_rst_n), 32'(m_dom()));
      chk("seq_busy", 32'(seq_busy), 32'(mode != M_IDLE));
      chk("cause", 32'(cause), 32'(m_cause));
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic clear_cause();
      cause_clr = 1'b1;
      step();
      cause_clr = 1'b0;
   endtask

   task automatic wait_dom0();
      for (int k = 0; k < 100 && dom_rst_n[0] !== 1'b1; k++) step();
      chk("wait_dom0", 32'(dom_rst_n[0]), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      rst_req   = '0;
      src_en    = '1;
      cause_clr = 1'b0;
      m_reset();
      #2;

      // power-on
      run(5);
      rst_n = 1'b1;
      run(44);
      chk("po_dom", 32'(dom_rst_n), 32'h7);
      chk("po_busy", 32'(seq_busy), 32'd0);
      chk("po_cause", 32'(cause), 32'd0);

      // glitch reject, then accepted pulse with edge-7 latency
      rst_req[1] = 1'b1;
      run(3);
      rst_req[1] = 1'b0;
      run(10);
      chk("glitch_dom", 32'(dom_rst_n), 32'h7);
      chk("glitch_cause", 32'(cause), 32'd0);
      rst_req[1] = 1'b1;
      run(4);
      rst_req[1] = 1'b0;
      run(2);
      chk("lat6_dom", 32'(dom_rst_n), 32'h7);
      run(1);
      chk("lat7_dom", 32'(dom_rst_n), 32'h0);
      chk("lat7_cause", 32'(cause), 32'h2);
      run(50);
      clear_cause();
      chk("clr_cause", 32'(cause), 32'd0);

      // long request
      rst_req[0] = 1'b1;
      run(100);
      chk("long_dom", 32'(dom_rst_n), 32'h0);
      rst_req[0] = 1'b0;
      run(60);
      chk("long_done", 32'(dom_rst_n), 32'h7);
      clear_cause();

      // re-trigger during release
      rst_req[0] = 1'b1;
      run(6);
      rst_req[0] = 1'b0;
      wait_dom0();
      rst_req[2] = 1'b1;
      run(6);
      rst_req[2] = 1'b0;
      run(1);
      chk("retrig_dom", 32'(dom_rst_n), 32'h0);
      run(60);
      chk("retrig_cause", 32'(cause), 32'h5);
      clear_cause();

      // masked source, then clear colliding with a new accept
      src_en[3]  = 1'b0;
      rst_req[3] = 1'b1;
      run(50);
      chk("mask_dom", 32'(dom_rst_n), 32'h7);
      chk("mask_cause", 32'(cause), 32'd0);
      rst_req[3] = 1'b0;
      src_en     = '1;
      run(5);
      rst_req[3] = 1'b1;
      run(6);
      clear_cause();
      chk("clr_race", 32'(cause[3]), 32'd1);
      rst_req[3] = 1'b0;
      run(60);
      clear_cause();

      // async reset during release
      rst_req[1] = 1'b1;
      run(6);
      rst_req[1] = 1'b0;
      wait_dom0();
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_dom", 32'(dom_rst_n), 32'h0);
      chk("arst_busy", 32'(seq_busy), 32'd1);
      chk("arst_cause", 32'(cause), 32'd0);
      step();
      rst_n = 1'b1;
      run(50);
      chk("arst_done", 32'(dom_rst_n), 32'h7);

      // random traffic
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 3) == 0)
            rst_req = 4'($urandom) & 4'($urandom);
         else
            rst_req = '0;
         if ($urandom_range(0, 4) == 0)
            src_en = 4'($urandom);
         else
            src_en = '1;
         cause_clr = ($urandom_range(0, 7) == 0);
         step();
         cause_clr = 1'b0;
         run($urandom_range(0, 8));
      end
      rst_req = '0;
      src_en  = '1;
      run(80);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
